// File: rtl/nn_pkg.sv
// nn_pkg: shared constants and FSM state encoding for the shared-MAC 4-8-1
// network sequencer.
//   N_IN/N_HID          : network shape (inputs per hidden neuron, hidden neurons)
//   W_W/HID_W/ACC_W     : weight, hidden-value and output-accumulator widths
//   ADDR_W              : weight ROM address width
//   HID_BASE/OUT_BASE   : ROM base addresses of hidden and output weight blocks
package nn_pkg;
  localparam int N_IN     = 4;
  localparam int N_HID    = 8;
  localparam int W_W      = 4;
  localparam int HID_W    = 10;
  localparam int ACC_W    = 23;
  localparam int ADDR_W   = 6;
  localparam int HID_BASE = 0;
  localparam int OUT_BASE = N_HID * N_IN;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HID   = 3'd1,
    S_OUT   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/nn_mac_unit.sv
// nn_mac_unit: the single shared multiply-accumulate lane.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   clr_i         : clear accumulator (new inference)
//   step_i        : consume one product this cycle
//   flush_i       : this product closes a sum; accumulator restarts at 0
//   out_mode_i    : 0 = hidden pass (x ? w : 0), 1 = output pass (hid * w)
//   x_bit_i       : input bit gating the hidden-pass weight
//   hid_i         : hidden value for the output pass
//   w_i           : weight from ROM
//   sum_o         : acc + product (ACC_W, upper bits truncated)
//   hid_sum_o     : acc + product saturated to HID_W
module nn_mac_unit #(
  parameter int W_W   = nn_pkg::W_W,
  parameter int HID_W = nn_pkg::HID_W,
  parameter int ACC_W = nn_pkg::ACC_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             step_i,
  input  logic             flush_i,
  input  logic             out_mode_i,
  input  logic             x_bit_i,
  input  logic [HID_W-1:0] hid_i,
  input  logic [W_W-1:0]   w_i,
  output logic [ACC_W-1:0] sum_o,
  output logic [HID_W-1:0] hid_sum_o
);
  localparam int PROD_W = HID_W + W_W;
  localparam logic [ACC_W:0] HID_MAX = (ACC_W+1)'((64'd1 << HID_W) - 64'd1);

  logic [ACC_W-1:0]  acc_q;
  logic [PROD_W-1:0] prod;
  logic [ACC_W:0]    wide;

  always_comb begin
    prod = '0;
    if (out_mode_i)   prod = PROD_W'(hid_i) * PROD_W'(w_i);
    else if (x_bit_i) prod = PROD_W'(w_i);
    // one spare bit so the hidden saturation compare sees any carry
    wide      = {1'b0, acc_q} + (ACC_W+1)'(prod);
    sum_o     = wide[ACC_W-1:0];
    hid_sum_o = (wide > HID_MAX) ? {HID_W{1'b1}} : wide[HID_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)       acc_q <= '0;
    else if (clr_i)  acc_q <= '0;
    else if (step_i) acc_q <= flush_i ? '0 : sum_o;
  end
endmodule

// File: rtl/nn_mac_sequencer.sv
// nn_mac_sequencer: time-multiplexed 4-8-1 network. Walks the weight ROM
// (hidden block then output block), feeding one shared MAC lane.
//   clk_i, rst_i : clock, synchronous active-high reset
//   en_i         : advance enable (0 = full stall, ROM reads suppressed)
//   start_i, x_i : start request and input vector, taken only in IDLE
//   w_addr_o, w_ren_o, w_rdata_i : synchronous ROM port, 1-cycle latency
//   busy_o, done_o, result_o, state_o : status and result
module nn_mac_sequencer #(
  parameter int N_IN   = nn_pkg::N_IN,
  parameter int N_HID  = nn_pkg::N_HID,
  parameter int W_W    = nn_pkg::W_W,
  parameter int HID_W  = nn_pkg::HID_W,
  parameter int ACC_W  = nn_pkg::ACC_W,
  parameter int ADDR_W = nn_pkg::ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              start_i,
  input  logic [N_IN-1:0]   x_i,
  output logic [ADDR_W-1:0] w_addr_o,
  output logic              w_ren_o,
  input  logic [W_W-1:0]    w_rdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ACC_W-1:0]  result_o,
  output logic [2:0]        state_o
);
  import nn_pkg::*;

  localparam int I_W = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int J_W = (N_IN  > 1) ? $clog2(N_IN)  : 1;

  // Travels alongside each ROM read so the returning datum knows its role.
  typedef struct packed {
    logic           vld;
    logic           out;   // output-pass term
    logic           last;  // closes a hidden sum / the output sum
    logic [I_W-1:0] idx;   // neuron index (hidden write / hidden read)
    logic           xb;    // input bit for hidden-pass terms
  } rom_tag_t;

  state_t                        state_q, state_d;
  logic [ADDR_W-1:0]             addr_q;
  logic [I_W-1:0]                i_q;
  logic [J_W-1:0]                j_q;
  logic [N_IN-1:0]               x_q;
  rom_tag_t                      tag_q;
  logic [N_HID-1:0][HID_W-1:0]   hid_q;
  logic [ACC_W-1:0]              result_q;
  logic                          accept, j_last, i_last;
  logic [ACC_W-1:0]              sum;
  logic [HID_W-1:0]              hid_sum;

  assign accept = (state_q == S_IDLE) && start_i && en_i;
  assign j_last = (j_q == J_W'(N_IN - 1));
  assign i_last = (i_q == I_W'(N_HID - 1));

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    w_ren_o = 1'b0;
    case (state_q)
      S_IDLE:  if (en_i && start_i) state_d = S_HID;
      S_HID: begin
        busy_o  = 1'b1;
        w_ren_o = en_i;
        if (en_i && i_last && j_last) state_d = S_OUT;
      end
      S_OUT: begin
        busy_o  = 1'b1;
        w_ren_o = en_i;
        if (en_i && i_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy_o = 1'b1;
        if (en_i) state_d = S_DONE;
      end
      S_DONE: begin
        done_o = en_i;
        if (en_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q   <= '0;
      i_q      <= '0;
      j_q      <= '0;
      x_q      <= '0;
      tag_q    <= '0;
      hid_q    <= '0;
      result_q <= '0;
    end else if (en_i) begin
      tag_q <= '0;
      case (state_q)
        S_IDLE: if (start_i) begin
          x_q      <= x_i;
          result_q <= '0;
          addr_q   <= ADDR_W'(HID_BASE);
          i_q      <= '0;
          j_q      <= '0;
        end
        S_HID: begin
          tag_q <= '{vld: 1'b1, out: 1'b0, last: j_last, idx: i_q, xb: x_q[j_q]};
          if (i_last && j_last) begin
            addr_q <= ADDR_W'(OUT_BASE);
            i_q    <= '0;
            j_q    <= '0;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
            if (j_last) begin
              j_q <= '0;
              i_q <= i_q + I_W'(1);
            end else begin
              j_q <= j_q + J_W'(1);
            end
          end
        end
        S_OUT: begin
          tag_q <= '{vld: 1'b1, out: 1'b1, last: i_last, idx: i_q, xb: 1'b0};
          if (i_last) begin
            addr_q <= '0;
            i_q    <= '0;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
            i_q    <= i_q + I_W'(1);
          end
        end
        default: ;
      endcase
      // Returning datum closes a sum: commit it. hid[N_HID-1] lands in the
      // first OUT cycle, well before the output pass reads it.
      if (tag_q.vld && tag_q.last) begin
        if (tag_q.out) result_q           <= sum;
        else           hid_q[tag_q.idx]   <= hid_sum;
      end
    end
  end

  nn_mac_unit #(.W_W(W_W), .HID_W(HID_W), .ACC_W(ACC_W)) u_mac (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (accept),
    .step_i     (en_i && tag_q.vld),
    .flush_i    (tag_q.last),
    .out_mode_i (tag_q.out),
    .x_bit_i    (tag_q.xb),
    .hid_i      (hid_q[tag_q.idx]),
    .w_i        (w_rdata_i),
    .sum_o      (sum),
    .hid_sum_o  (hid_sum)
  );

  assign w_addr_o = addr_q;
  assign result_o = result_q;
  assign state_o  = state_q;
endmodule

// File: tb/tb_nn_mac_sequencer.sv
// Bench for nn_mac_sequencer: 1-cycle ROM model, directed scenarios plus
// randomized inputs/weights/stalls against a plain-arithmetic network model.
module tb_nn_mac_sequencer;
  logic        clk = 1'b0;
  logic        rst, en, start;
  logic [3:0]  x;
  logic [5:0]  w_addr;
  logic        w_ren;
  logic [3:0]  w_rdata = '0;
  logic        busy, done;
  logic [22:0] result;
  logic [2:0]  state;

  int          rom [64];
  int          n_chk = 0, n_fail = 0;
  logic [5:0]  addr_log [$];

  always #5 clk = ~clk;

  nn_mac_sequencer dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .start_i(start), .x_i(x),
    .w_addr_o(w_addr), .w_ren_o(w_ren), .w_rdata_i(w_rdata),
    .busy_o(busy), .done_o(done), .result_o(result), .state_o(state)
  );

  // synchronous ROM: data appears after the edge that sees w_ren, held otherwise
  always @(posedge clk) if (w_ren === 1'b1) begin
    w_rdata <= 4'(rom[w_addr]);
    addr_log.push_back(w_addr);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // network as the arithmetic defines it
  function automatic int model(input logic [3:0] xv);
    int h, acc;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      h = 0;
      for (int j = 0; j < 4; j++) if (xv[j]) h += rom[i*4 + j];
      if (h > 1023) h = 1023;
      acc += h * rom[32 + i];
    end
    return acc % (1 << 23);
  endfunction

  task automatic load_default_rom();
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 4; j++) rom[i*4 + j] = (i < 4) ? j + 1 : j + 5;
      rom[32 + i] = i + 1;
    end
  endtask

  // Called just after a negedge with the DUT in IDLE. stall: 0 none,
  // 1 fixed windows (cycles 10-14, 35-39), 2 random. Cycle c ends at the
  // c-th posedge after the accepting edge.
  task automatic run_inf(input logic [3:0] xv, input int stall, input bit repulse,
                         input int rst_at, input int tail, input string tag);
    int cyc, en_cnt, done_cnt, done_en, done_cyc, exp_res, bad;
    en_cnt = 0; done_cnt = 0; done_en = 0; done_cyc = 0;
    exp_res = model(xv);
    addr_log.delete();
    x = xv; start = 1'b1; en = 1'b1;
    @(posedge clk);
    for (cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      case (stall)
        1:       en = !((cyc >= 10 && cyc < 15) || (cyc >= 35 && cyc < 40));
        2:       en = ($urandom_range(0, 3) != 0);
        default: en = 1'b1;
      endcase
      start = repulse && (cyc == 5 || cyc == 42);
      rst   = (cyc == rst_at);
      x     = 4'($urandom);
      #1;
      if (cyc == 1) begin
        chk({tag, "_res_clr"}, 32'(result), 0);
        chk({tag, "_state_hid"}, 32'(state), 1);
      end
      if (rst_at != 0 && cyc == rst_at + 1) begin
        chk({tag, "_rst_state"}, 32'(state), 0);
        chk({tag, "_rst_outs"}, {busy, done, w_ren, w_addr, result}, 0);
        return;
      end
      if (en) en_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_en  = en_cnt;
          done_cyc = cyc;
          chk({tag, "_result"}, 32'(result), 32'(exp_res));
          chk({tag, "_done_state"}, {busy, 1'b0, state}, 32'd4);
        end
      end
      if (done_cnt > 0 && cyc >= done_cyc + tail) break;
    end
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_latency_en"}, done_en, 42);
    if (stall != 2) chk({tag, "_done_cyc"}, done_cyc, (stall == 1) ? 52 : 42);
    if (tail > 0) chk({tag, "_tail_idle"}, {busy, state, result}, {1'b0, 3'd0, 23'(exp_res)});
    bad = 0;
    foreach (addr_log[k]) if (addr_log[k] != 6'(k)) bad++;
    chk({tag, "_addr_n"}, addr_log.size(), 40);
    chk({tag, "_addr_bad"}, bad, 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; start = 1'b0; x = '0;
    load_default_rom();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_state", 32'(state), 0);
    chk("reset_outs", {busy, done, w_ren, w_addr, result}, 0);
    @(negedge clk);
    rst = 1'b0;
    // start with en low must not be taken
    start = 1'b1; en = 1'b0; x = 4'hF;
    @(negedge clk); #1;
    chk("stall_no_accept", {busy, state}, 0);
    start = 1'b0; en = 1'b1;
    @(negedge clk);

    run_inf(4'hF, 0, 1'b0, 0, 0, "t1");
    chk("t1_const", 32'(result), 776);
    @(negedge clk);
    run_inf(4'h0, 0, 1'b0, 0, 0, "t2");
    chk("t2_const", 32'(result), 0);
    @(negedge clk);
    run_inf(4'hF, 1, 1'b0, 0, 0, "t3");
    chk("t3_const", 32'(result), 776);
    @(negedge clk);
    run_inf(4'hF, 0, 1'b1, 0, 10, "t4");
    @(negedge clk);
    run_inf(4'hF, 0, 1'b0, 20, 0, "t5a");
    @(negedge clk);
    run_inf(4'b0101, 0, 1'b0, 0, 0, "t5b");
    @(negedge clk);
    run_inf(4'b0011, 0, 1'b0, 0, 0, "t6a");
    @(negedge clk);
    run_inf(4'b1110, 0, 1'b0, 0, 0, "t6b");

    // all-max weights: largest sums the default widths see
    for (int a = 0; a < 64; a++) rom[a] = 15;
    @(negedge clk);
    run_inf(4'hF, 2, 1'b0, 0, 0, "tmax");
    chk("tmax_const", 32'(result), 7200);

    for (int r = 0; r < 10; r++) begin
      for (int a = 0; a < 64; a++) rom[a] = $urandom_range(0, 15);
      @(negedge clk);
      run_inf(4'($urandom), 2, 1'b0, 0, 0, $sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
